// File: rtl/bp_nonsynth_cosim_scheduler.sv
// Cosimulation commit scheduler.
// Several cores each offer one commit entry at a time. The scheduler picks
// one entry round-robin and sends it to a single golden-model step port.
// It then waits for the model's verdict before it picks the next entry.
// It also tracks per-core finish and raises sticky pass/fail/hang status.
module bp_nonsynth_cosim_scheduler #(
    parameter int num_core_p    = 4,
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int dword_width_p = 64,
    parameter int timeout_p     = 1024,
    localparam int hart_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                en_i,
    input  logic [num_core_p-1:0]               commit_v_i,
    output logic [num_core_p-1:0]               commit_ready_o,
    input  logic [num_core_p-1:0]               commit_trap_i,
    input  logic [num_core_p*vaddr_width_p-1:0] commit_pc_i,
    input  logic [num_core_p*instr_width_p-1:0] commit_instr_i,
    input  logic [num_core_p*dword_width_p-1:0] commit_data_i,
    input  logic [num_core_p-1:0]               finish_i,
    output logic                                step_v_o,
    input  logic                                step_ready_i,
    output logic [hart_width_lp-1:0]            step_hart_o,
    output logic                                step_trap_o,
    output logic [63:0]                         step_pc_o,
    output logic [instr_width_p-1:0]            step_instr_o,
    output logic [dword_width_p-1:0]            step_data_o,
    input  logic                                result_v_i,
    input  logic                                result_fail_i,
    output logic                                pass_o,
    output logic                                fail_o,
    output logic                                hang_o
);

    localparam int cnt_width_lp = $clog2(timeout_p + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    state_t                     state_r;
    state_t                     state_next_s;
    logic [hart_width_lp-1:0]   rr_r;
    logic [num_core_p-1:0]      finished_r;
    logic [cnt_width_lp-1:0]    hang_cnt_r;
    logic                       hang_r;
    logic [hart_width_lp-1:0]   cap_hart_r;
    logic                       cap_trap_r;
    logic [63:0]                cap_pc_r;
    logic [instr_width_p-1:0]   cap_instr_r;
    logic [dword_width_p-1:0]   cap_data_r;

    logic [num_core_p-1:0]      eligible_s;
    logic                       all_finished_s;
    logic                       grant_found_s;
    logic [hart_width_lp-1:0]   grant_idx_s;
    logic                       grant_s;
    logic                       hang_inc_s;
    logic                       hang_hit_s;
    logic                       sel_trap_s;
    logic [vaddr_width_p-1:0]   sel_pc_s;
    logic [instr_width_p-1:0]   sel_instr_s;
    logic [dword_width_p-1:0]   sel_data_s;

    // A core that raises finish in the same cycle it commits still counts as eligible.
    assign eligible_s     = commit_v_i & ~finished_r;
    assign all_finished_s = &finished_r;
    assign grant_s        = (state_r == ST_IDLE) && en_i && grant_found_s;
    assign hang_inc_s     = (state_r == ST_IDLE) && en_i && !grant_found_s && !all_finished_s;
    assign hang_hit_s     = hang_inc_s && (hang_cnt_r == cnt_width_lp'(timeout_p - 1));

    // Round-robin search: the first eligible core at or after the pointer, wrapping around.
    always_comb begin
        int idx_v;
        idx_v         = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < num_core_p; i++) begin
            idx_v = int'(rr_r) + i;
            if (idx_v >= num_core_p) begin
                idx_v = idx_v - num_core_p;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_found_s && eligible_s[hart_width_lp'(idx_v)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = hart_width_lp'(idx_v);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Select the granted core's payload slice from the flattened buses.
    always_comb begin
        sel_trap_s  = 1'b0;
        sel_pc_s    = '0;
        sel_instr_s = '0;
        sel_data_s  = '0;
        for (int i = 0; i < num_core_p; i++) begin
            if (grant_idx_s == hart_width_lp'(i)) begin
                sel_trap_s  = commit_trap_i[i];
                sel_pc_s    = commit_pc_i[i*vaddr_width_p +: vaddr_width_p];
                sel_instr_s = commit_instr_i[i*instr_width_p +: instr_width_p];
                sel_data_s  = commit_data_i[i*dword_width_p +: dword_width_p];
            end else begin
                sel_trap_s  = sel_trap_s;
            end
        end
    end

    // State register; reset discards any in-flight entry.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE and FAIL are absorbing.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_next_s = ST_ISSUE;
                end else if (all_finished_s) begin
                    state_next_s = ST_DONE;
                end else if (hang_hit_s) begin
                    state_next_s = ST_FAIL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (step_ready_i) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (result_v_i) begin
                    state_next_s = result_fail_i ? ST_FAIL : ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_DONE;
            ST_FAIL: state_next_s = ST_FAIL;
            default: state_next_s = ST_FAIL;
        endcase
    end

    // Outputs. Accept is gated by reset so that nothing is acknowledged while the block is held in reset.
    always_comb begin
        commit_ready_o = '0;
        if (reset_i && grant_s) begin
            commit_ready_o[grant_idx_s] = 1'b1;
        end else begin
            commit_ready_o = '0;
        end
        step_v_o     = (state_r == ST_ISSUE);
        pass_o       = (state_r == ST_DONE);
        fail_o       = (state_r == ST_FAIL);
        hang_o       = hang_r;
        step_hart_o  = cap_hart_r;
        step_trap_o  = cap_trap_r;
        step_pc_o    = cap_pc_r;
        step_instr_o = cap_instr_r;
        step_data_o  = cap_data_r;
    end

    // Capture the granted payload and sign-extend the PC to 64 bits.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cap_hart_r  <= '0;
            cap_trap_r  <= 1'b0;
            cap_pc_r    <= 64'd0;
            cap_instr_r <= '0;
            cap_data_r  <= '0;
        end else if (grant_s) begin
            cap_hart_r  <= grant_idx_s;
            cap_trap_r  <= sel_trap_s;
            cap_pc_r    <= {{(64-vaddr_width_p){sel_pc_s[vaddr_width_p-1]}}, sel_pc_s};
            cap_instr_r <= sel_instr_s;
            cap_data_r  <= sel_data_s;
        end
    end

    // Advance the round-robin pointer past the core whose entry the model accepted.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_r <= '0;
        end else if ((state_r == ST_WAIT) && result_v_i && !result_fail_i) begin
            rr_r <= (cap_hart_r == hart_width_lp'(num_core_p - 1)) ? '0 : cap_hart_r + hart_width_lp'(1);
        end
    end

    // Sticky per-core finished flags.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            finished_r <= '0;
        end else begin
            finished_r <= finished_r | finish_i;
        end
    end

    // Hang counter: counts enabled idle cycles with nothing to schedule, restarts on any grant, and saturates.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            hang_cnt_r <= '0;
            hang_r     <= 1'b0;
        end else begin
            if (grant_s) begin
                hang_cnt_r <= '0;
            end else if (hang_inc_s && (hang_cnt_r != cnt_width_lp'(timeout_p))) begin
                hang_cnt_r <= hang_cnt_r + cnt_width_lp'(1);
            end
            if (hang_hit_s) begin
                hang_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_cosim_scheduler.sv
// Directed bench for bp_nonsynth_cosim_scheduler (4 cores, 16-cycle hang timeout).
module tb_bp_nonsynth_cosim_scheduler;

    localparam int nc = 4;
    localparam int va = 39;
    localparam int iw = 32;
    localparam int dw = 64;

    logic               clk_i;
    logic               reset_i;
    logic               en_i;
    logic [nc-1:0]      commit_v_i;
    logic [nc-1:0]      commit_ready_o;
    logic [nc-1:0]      commit_trap_i;
    logic [nc*va-1:0]   commit_pc_i;
    logic [nc*iw-1:0]   commit_instr_i;
    logic [nc*dw-1:0]   commit_data_i;
    logic [nc-1:0]      finish_i;
    logic               step_v_o;
    logic               step_ready_i;
    logic [1:0]         step_hart_o;
    logic               step_trap_o;
    logic [63:0]        step_pc_o;
    logic [iw-1:0]      step_instr_o;
    logic [dw-1:0]      step_data_o;
    logic               result_v_i;
    logic               result_fail_i;
    logic               pass_o;
    logic               fail_o;
    logic               hang_o;

    int check_count = 0;
    int error_count = 0;

    bp_nonsynth_cosim_scheduler #(
        .num_core_p(nc), .vaddr_width_p(va), .instr_width_p(iw),
        .dword_width_p(dw), .timeout_p(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
        .commit_v_i(commit_v_i), .commit_ready_o(commit_ready_o),
        .commit_trap_i(commit_trap_i), .commit_pc_i(commit_pc_i),
        .commit_instr_i(commit_instr_i), .commit_data_i(commit_data_i),
        .finish_i(finish_i), .step_v_o(step_v_o), .step_ready_i(step_ready_i),
        .step_hart_o(step_hart_o), .step_trap_o(step_trap_o), .step_pc_o(step_pc_o),
        .step_instr_o(step_instr_o), .step_data_o(step_data_o),
        .result_v_i(result_v_i), .result_fail_i(result_fail_i),
        .pass_o(pass_o), .fail_o(fail_o), .hang_o(hang_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int c, input logic trap, input logic [va-1:0] pc,
                            input logic [iw-1:0] instr, input logic [dw-1:0] data);
        commit_trap_i[c]          = trap;
        commit_pc_i[c*va +: va]   = pc;
        commit_instr_i[c*iw +: iw] = instr;
        commit_data_i[c*dw +: dw] = data;
    endtask

    task automatic clear_inputs;
        en_i = 1'b0; commit_v_i = '0; commit_trap_i = '0; commit_pc_i = '0;
        commit_instr_i = '0; commit_data_i = '0; finish_i = '0;
        step_ready_i = 1'b0; result_v_i = 1'b0; result_fail_i = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk_i);
        reset_i = 1'b0;
        clear_inputs();
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    // Called on the negedge after an accept; leaves off on the negedge after the verdict is consumed.
    task automatic serve(input int hart, input logic [63:0] pc, input logic [iw-1:0] instr,
                         input logic [dw-1:0] data, input logic trap, input logic fail);
        check_value("issue_v", step_v_o, 1);
        check_value("issue_hart", step_hart_o, hart);
        check_value("issue_pc", step_pc_o, pc);
        check_value("issue_instr", step_instr_o, instr);
        check_value("issue_data", step_data_o, data);
        check_value("issue_trap", step_trap_o, trap);
        check_value("issue_no_ready", commit_ready_o, 0);
        commit_v_i[hart] = 1'b0;
        step_ready_i = 1'b1;
        @(negedge clk_i);
        check_value("wait_v", step_v_o, 0);
        step_ready_i = 1'b0;
        result_v_i = 1'b1;
        result_fail_i = fail;
        @(negedge clk_i);
        result_v_i = 1'b0;
        result_fail_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0;
        clear_inputs();
        commit_v_i = 4'hF;
        en_i = 1'b1;
        #1;
        check_value("rst_ready", commit_ready_o, 0);
        check_value("rst_step_v", step_v_o, 0);
        check_value("rst_pc", step_pc_o, 0);
        check_value("rst_status", {pass_o, fail_o, hang_o}, 0);

        // Round-robin ordering and pointer advance.
        do_reset();
        en_i = 1'b1;
        set_core(0, 1'b0, 39'h100, 32'h13, 64'h11);
        set_core(1, 1'b0, 39'h080, 32'h33, 64'h44);
        set_core(2, 1'b0, 39'h200, 32'h93, 64'h22);
        set_core(3, 1'b0, 39'h300, 32'h113, 64'h33);
        commit_v_i = 4'b0101;
        #1 check_value("rr_first", commit_ready_o, 4'b0001);
        @(negedge clk_i);
        serve(0, 64'h100, 32'h13, 64'h11, 1'b0, 1'b0);
        #1 check_value("rr_second", commit_ready_o, 4'b0100);
        @(negedge clk_i);
        serve(2, 64'h200, 32'h93, 64'h22, 1'b0, 1'b0);
        commit_v_i = 4'b1111;
        #1 check_value("rr_ptr3", commit_ready_o, 4'b1000);
        @(negedge clk_i);
        serve(3, 64'h300, 32'h113, 64'h33, 1'b0, 1'b0);
        #1 check_value("rr_wrap", commit_ready_o, 4'b0001);
        en_i = 1'b0;
        #1 check_value("en_low_block", commit_ready_o, 4'b0000);
        commit_v_i = '0;

        // Sign extension, hold under backpressure, early result ignored, enable drop in flight.
        do_reset();
        en_i = 1'b1;
        set_core(1, 1'b0, 39'h40_0000_0000, 32'h0000_0013, 64'hDEAD_BEEF_0000_0001);
        commit_v_i = 4'b0010;
        #1 check_value("sx_ready", commit_ready_o, 4'b0010);
        @(negedge clk_i);
        check_value("sx_v_latency", step_v_o, 1);
        check_value("sx_pc", step_pc_o, 64'hFFFF_FFC0_0000_0000);
        check_value("sx_hart", step_hart_o, 1);
        commit_v_i = '0;
        set_core(1, 1'b0, 39'h1234, 32'h0, 64'h0);
        en_i = 1'b0;
        result_v_i = 1'b1;
        result_fail_i = 1'b1;
        @(negedge clk_i);
        result_v_i = 1'b0;
        result_fail_i = 1'b0;
        check_value("hold_v1", step_v_o, 1);
        check_value("hold_pc1", step_pc_o, 64'hFFFF_FFC0_0000_0000);
        check_value("early_result_ignored", fail_o, 0);
        @(negedge clk_i);
        check_value("hold_v2", step_v_o, 1);
        check_value("hold_data2", step_data_o, 64'hDEAD_BEEF_0000_0001);
        step_ready_i = 1'b1;
        @(negedge clk_i);
        check_value("en_low_wait", step_v_o, 0);
        step_ready_i = 1'b0;
        result_v_i = 1'b1;
        @(negedge clk_i);
        result_v_i = 1'b0;
        set_core(1, 1'b1, 39'h3F_FFFF_FFF0, 32'h0000_0073, 64'h8000_0000_0000_0003);
        commit_v_i = 4'b0010;
        #1 check_value("en_low_idle", commit_ready_o, 4'b0000);
        en_i = 1'b1;
        #1 check_value("en_high_idle", commit_ready_o, 4'b0010);

        // Trap entry and a model mismatch: FAIL is absorbing.
        @(negedge clk_i);
        serve(1, 64'h0000_003F_FFFF_FFF0, 32'h0000_0073, 64'h8000_0000_0000_0003, 1'b1, 1'b1);
        check_value("mismatch_fail", fail_o, 1);
        check_value("mismatch_pass", pass_o, 0);
        commit_v_i = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_value("fail_absorb", {fail_o, pass_o}, 2'b10);
            check_value("fail_no_ready", commit_ready_o, 0);
        end

        // A commit in the same cycle as the first finish is still eligible.
        do_reset();
        en_i = 1'b1;
        set_core(0, 1'b0, 39'h500, 32'h73, 64'h55);
        commit_v_i = 4'b0001;
        finish_i = 4'b1111;
        #1 check_value("finish_same_cycle", commit_ready_o, 4'b0001);
        @(negedge clk_i);
        finish_i = '0;
        serve(0, 64'h500, 32'h73, 64'h55, 1'b0, 1'b0);
        check_value("done_not_yet", pass_o, 0);
        @(negedge clk_i);
        check_value("done_pass", {pass_o, fail_o}, 2'b10);

        // All cores finish with nothing pending.
        do_reset();
        en_i = 1'b1;
        finish_i = 4'b1111;
        @(negedge clk_i);
        finish_i = '0;
        check_value("finish_pass_early", pass_o, 0);
        @(negedge clk_i);
        check_value("finish_pass", {pass_o, fail_o}, 2'b10);
        commit_v_i = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_value("done_absorb", {pass_o, fail_o}, 2'b10);
            check_value("done_no_ready", commit_ready_o, 0);
        end

        // Hang timeout with a grant in the middle restarting the count.
        do_reset();
        en_i = 1'b1;
        finish_i = 4'b0111;
        @(negedge clk_i);
        finish_i = '0;
        repeat (8) @(negedge clk_i);
        check_value("hang_before_grant", hang_o, 0);
        set_core(3, 1'b0, 39'h700, 32'h17, 64'h77);
        commit_v_i = 4'b1000;
        #1 check_value("hang_grant_ready", commit_ready_o, 4'b1000);
        @(negedge clk_i);
        serve(3, 64'h700, 32'h17, 64'h77, 1'b0, 1'b0);
        repeat (4) @(negedge clk_i);
        check_value("hang_restarted", {hang_o, fail_o}, 2'b00);
        repeat (11) @(negedge clk_i);
        check_value("hang_edge_minus1", {hang_o, fail_o}, 2'b00);
        @(negedge clk_i);
        check_value("hang_hit", {hang_o, fail_o, pass_o}, 3'b110);
        #2 reset_i = 1'b0;
        #1 check_value("async_rst_status", {pass_o, fail_o, hang_o}, 3'b000);

        // Asynchronous reset during WAIT and during ISSUE.
        do_reset();
        en_i = 1'b1;
        set_core(2, 1'b0, 39'h600, 32'h37, 64'h66);
        commit_v_i = 4'b0100;
        @(negedge clk_i);
        check_value("rst_wait_pre", step_v_o, 1);
        commit_v_i = '0;
        step_ready_i = 1'b1;
        @(negedge clk_i);
        step_ready_i = 1'b0;
        #2 reset_i = 1'b0;
        #1 check_value("rst_wait_v", step_v_o, 0);
        check_value("rst_wait_pc", step_pc_o, 0);
        check_value("rst_wait_status", {pass_o, fail_o, hang_o}, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        commit_v_i = 4'b0100;
        @(negedge clk_i);
        check_value("rst_issue_pre", step_v_o, 1);
        commit_v_i = '0;
        #2 reset_i = 1'b0;
        #1 check_value("rst_issue_v", step_v_o, 0);
        check_value("rst_issue_data", step_data_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        check_value("rst_discarded", step_v_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
